// File: rtl/tblink_rpc_cmd_exec.sv
// Executes decoded tblink RPC commands (NOP/WRITE/READ/POLL) as byte accesses on a req/ack register bus.
// Optional bus watchdog enabled by defining TBLINK_RPC_CMD_EXEC_BUSTO_EN.
//
// state      | meaning
// S_IDLE     | waiting for put_i != get_i; latches the command
// S_CAPTURE  | decode and size check; launches bus request or goes to DONE
// S_BUS      | request held until ack (or watchdog expiry)
// S_POLL_CHK | evaluates last access; finishes or re-issues POLL read
// S_DONE     | registers response and toggles get_i
module tblink_rpc_cmd_exec #(
    parameter int CMD_IN_PARAMS_SZ = 4,
    parameter int CMD_IN_RSP_SZ    = 1,
    parameter int POLL_MAX         = 255,
    parameter int BUS_TO           = 16
) (
    input  logic                          uclock,
    input  logic                          reset,
    input  logic [7:0]                    cmd_in,
    input  logic [7:0]                    cmd_in_sz,
    input  logic [CMD_IN_PARAMS_SZ*8-1:0] cmd_in_params,
    input  logic                          cmd_in_put_i,
    output logic                          cmd_in_get_i,
    output logic [CMD_IN_RSP_SZ*8-1:0]    cmd_in_rsp,
    output logic [7:0]                    cmd_in_rsp_sz,
    output logic                          bus_req,
    output logic                          bus_we,
    output logic [7:0]                    bus_addr,
    output logic [7:0]                    bus_wdata,
    input  logic [7:0]                    bus_rdata,
    input  logic                          bus_ack,
    output logic                          busy
);

    generate
        if (CMD_IN_PARAMS_SZ < 3 || CMD_IN_RSP_SZ < 1 || POLL_MAX < 1 || POLL_MAX > 255 || BUS_TO < 1)
        begin : g_param_check
            $error("tblink_rpc_cmd_exec: parameter out of range");
        end
    endgenerate

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] OP_POLL  = 8'h03;

    localparam logic [7:0] RSP_OK      = 8'h00;
    localparam logic [7:0] RSP_POLL_TO = 8'hFF;
    localparam logic [7:0] RSP_BAD_CMD = 8'hFE;
    localparam logic [7:0] RSP_BUS_TO  = 8'hFD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_BUS,
        S_POLL_CHK,
        S_DONE
    } state_t;

    state_t     state;
    logic [7:0] op_q;
    logic [7:0] sz_q;
    logic [7:0] addr_q;
    logic [7:0] p1_q;
    logic [7:0] p2_q;
    logic [7:0] rdata_q;
    logic [7:0] poll_cnt;
    logic [7:0] rsp_n;
    logic [7:0] rsp_sz_n;
    logic [7:0] rsp_q;
    logic       get_q;

    // Only the first three parameter bytes carry meaning for the supported opcodes.
    logic unused_params;
    assign unused_params = ^cmd_in_params;

`ifdef TBLINK_RPC_CMD_EXEC_BUSTO_EN
    localparam int WD_W = $clog2(BUS_TO) + 1;
    logic [WD_W-1:0] wd_cnt;
`endif

    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            op_q          <= '0;
            sz_q          <= '0;
            addr_q        <= '0;
            p1_q          <= '0;
            p2_q          <= '0;
            rdata_q       <= '0;
            poll_cnt      <= '0;
            rsp_n         <= '0;
            rsp_sz_n      <= '0;
            rsp_q         <= '0;
            cmd_in_rsp_sz <= '0;
            get_q         <= 1'b0;
            bus_req       <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            busy          <= 1'b0;
`ifdef TBLINK_RPC_CMD_EXEC_BUSTO_EN
            wd_cnt        <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_in_put_i != get_q) begin
                        op_q   <= cmd_in;
                        sz_q   <= cmd_in_sz;
                        addr_q <= cmd_in_params[7:0];
                        p1_q   <= cmd_in_params[15:8];
                        p2_q   <= cmd_in_params[23:16];
                        busy   <= 1'b1;
                        state  <= S_CAPTURE;
                    end
                end

                S_CAPTURE: begin
                    poll_cnt <= '0;
`ifdef TBLINK_RPC_CMD_EXEC_BUSTO_EN
                    wd_cnt   <= '0;
`endif
                    if (op_q == OP_NOP && sz_q == 8'd0) begin
                        rsp_n    <= RSP_OK;
                        rsp_sz_n <= 8'd0;
                        state    <= S_DONE;
                    end else if (op_q == OP_WRITE && sz_q == 8'd2) begin
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b1;
                        bus_addr  <= addr_q;
                        bus_wdata <= p1_q;
                        state     <= S_BUS;
                    end else if ((op_q == OP_READ && sz_q == 8'd1) ||
                                 (op_q == OP_POLL && sz_q == 8'd3)) begin
                        bus_req  <= 1'b1;
                        bus_we   <= 1'b0;
                        bus_addr <= addr_q;
                        state    <= S_BUS;
                    end else begin
                        rsp_n    <= RSP_BAD_CMD;
                        rsp_sz_n <= 8'd1;
                        state    <= S_DONE;
                    end
                end

                S_BUS: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        rdata_q <= bus_rdata;
                        if (poll_cnt != 8'hFF) begin
                            poll_cnt <= poll_cnt + 8'd1;
                        end
                        state <= S_POLL_CHK;
                    end
`ifdef TBLINK_RPC_CMD_EXEC_BUSTO_EN
                    else if (wd_cnt == WD_W'(BUS_TO - 1)) begin
                        bus_req  <= 1'b0;
                        rsp_n    <= RSP_BUS_TO;
                        rsp_sz_n <= 8'd1;
                        state    <= S_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end

                S_POLL_CHK: begin
                    rsp_sz_n <= 8'd1;
                    if (op_q == OP_READ) begin
                        rsp_n <= rdata_q;
                        state <= S_DONE;
                    end else if (op_q == OP_POLL) begin
                        if ((rdata_q & p1_q) == p2_q) begin
                            rsp_n <= RSP_OK;
                            state <= S_DONE;
                        end else if (poll_cnt == 8'(POLL_MAX)) begin
                            rsp_n <= RSP_POLL_TO;
                            state <= S_DONE;
                        end else begin
                            bus_req <= 1'b1;
`ifdef TBLINK_RPC_CMD_EXEC_BUSTO_EN
                            wd_cnt  <= '0;
`endif
                            state   <= S_BUS;
                        end
                    end else begin
                        rsp_n <= RSP_OK;
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    rsp_q         <= rsp_n;
                    cmd_in_rsp_sz <= rsp_sz_n;
                    get_q         <= ~get_q;
                    busy          <= 1'b0;
                    state         <= S_IDLE;
                end

                default: begin
                    bus_req <= 1'b0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_in_get_i = get_q;

    always_comb begin
        cmd_in_rsp      = '0;
        cmd_in_rsp[7:0] = rsp_q;
    end

endmodule

// File: tb/tb_tblink_rpc_cmd_exec.sv
// Scoreboard bench for tblink_rpc_cmd_exec: responses and bus accesses are checked by monitors
// against queues filled at issue time. Honours TBLINK_RPC_CMD_EXEC_BUSTO_EN for the watchdog case.
module tb_tblink_rpc_cmd_exec;

    logic        uclock = 1'b0;
    logic        reset  = 1'b1;
    logic [7:0]  cmd_in = '0;
    logic [7:0]  cmd_in_sz = '0;
    logic [31:0] cmd_in_params = '0;
    logic        cmd_in_put_i = 1'b0;
    logic        cmd_in_get_i;
    logic [7:0]  cmd_in_rsp;
    logic [7:0]  cmd_in_rsp_sz;
    logic        bus_req;
    logic        bus_we;
    logic [7:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic        busy;

    tblink_rpc_cmd_exec #(
        .CMD_IN_PARAMS_SZ(4),
        .CMD_IN_RSP_SZ   (1),
        .POLL_MAX        (5),
        .BUS_TO          (16)
    ) dut (
        .uclock       (uclock),
        .reset        (reset),
        .cmd_in       (cmd_in),
        .cmd_in_sz    (cmd_in_sz),
        .cmd_in_params(cmd_in_params),
        .cmd_in_put_i (cmd_in_put_i),
        .cmd_in_get_i (cmd_in_get_i),
        .cmd_in_rsp   (cmd_in_rsp),
        .cmd_in_rsp_sz(cmd_in_rsp_sz),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack),
        .busy         (busy)
    );

    always #5 uclock = ~uclock;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_rsp_q[$];   // {rsp, rsp_sz}
    logic [16:0] exp_bus_q[$];   // {we, addr, wdata}; wdata ignored for reads
    logic [7:0]  rd_q[$];

    int  ack_delay = 0;
    bit  never_ack = 1'b0;
    int  wait_cnt  = 0;
    int  n_acks    = 0;
    logic prev_get = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge uclock) begin
        logic [15:0] e;
        if (reset) begin
            prev_get = 1'b0;
        end else if (cmd_in_get_i !== prev_get) begin
            prev_get = cmd_in_get_i;
            n_cmp++;
            if (exp_rsp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rsp: got rsp=0x%0h sz=%0d, expected no response", cmd_in_rsp, cmd_in_rsp_sz);
            end else begin
                e = exp_rsp_q.pop_front();
                if (cmd_in_rsp_sz !== e[7:0]) begin
                    n_err++;
                    $display("FAIL rsp_sz: got %0d, expected %0d", cmd_in_rsp_sz, e[7:0]);
                end
                if (e[7:0] != 8'd0) begin
                    n_cmp++;
                    if (cmd_in_rsp !== e[15:8]) begin
                        n_err++;
                        $display("FAIL rsp: got 0x%0h, expected 0x%0h", cmd_in_rsp, e[15:8]);
                    end
                end
            end
        end
    end

    // Bus slave model with access scoreboard
    always @(negedge uclock) begin
        logic [16:0] e;
        if (reset || !bus_req) begin
            bus_ack  = 1'b0;
            wait_cnt = 0;
        end else if (bus_ack) begin
            bus_ack = 1'b0;
        end else if (!never_ack) begin
            if (wait_cnt == ack_delay) begin
                bus_ack   = 1'b1;
                bus_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 8'h00;
                wait_cnt  = 0;
                n_acks++;
                n_cmp++;
                if (exp_bus_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_bus: got we=%0b addr=0x%0h, expected no access", bus_we, bus_addr);
                end else begin
                    e = exp_bus_q.pop_front();
                    if (bus_we !== e[16] || bus_addr !== e[15:8] || (e[16] && bus_wdata !== e[7:0])) begin
                        n_err++;
                        $display("FAIL bus_access: got we=%0b addr=0x%0h wdata=0x%0h, expected we=%0b addr=0x%0h wdata=0x%0h",
                                 bus_we, bus_addr, bus_wdata, e[16], e[15:8], e[7:0]);
                    end
                end
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic issue(input logic [7:0] c, input logic [7:0] s, input logic [31:0] p,
                         input logic [7:0] ersp, input logic [7:0] ersp_sz, input bit push);
        cmd_in        = c;
        cmd_in_sz     = s;
        cmd_in_params = p;
        if (push) exp_rsp_q.push_back({ersp, ersp_sz});
        cmd_in_put_i  = ~cmd_in_put_i;
    endtask

    task automatic wait_done(input string name, output int cyc);
        cyc = 0;
        while (cmd_in_get_i !== cmd_in_put_i && cyc < 400) begin
            @(negedge uclock);
            cyc++;
        end
        if (cyc >= 400) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no completion in %0d cycles, expected completion", name, cyc);
        end
    endtask

    task automatic run(input string name, input logic [7:0] c, input logic [7:0] s, input logic [31:0] p,
                       input logic [7:0] ersp, input logic [7:0] ersp_sz, input int exp_reqs, input int exp_lat);
        int cyc;
        n_acks = 0;
        issue(c, s, p, ersp, ersp_sz, 1'b1);
        wait_done(name, cyc);
        check({name, "_reqs"}, n_acks, exp_reqs);
        if (exp_lat > 0) check({name, "_latency"}, cyc, exp_lat);
    endtask

    initial begin
        int cyc;
        int req_hi;
        repeat (3) @(negedge uclock);
        check("rst_get",    {31'd0, cmd_in_get_i}, 0);
        check("rst_rsp",    cmd_in_rsp, 0);
        check("rst_rsp_sz", cmd_in_rsp_sz, 0);
        check("rst_bus",    {bus_req, bus_we, bus_addr, bus_wdata}, 0);
        check("rst_busy",   {31'd0, busy}, 0);
        reset = 1'b0;
        @(negedge uclock);

        // NOP: toggle two edges after detection; observed 3 negedges after put toggles
        run("nop", 8'h00, 8'd0, 32'h0, 8'h00, 8'd0, 0, 3);

        // WRITE with ack after 3 cycles, then with ack on first req cycle (latency 4 -> 5 negedges)
        ack_delay = 3;
        exp_bus_q.push_back({1'b1, 8'h10, 8'hA5});
        run("write_slow", 8'h01, 8'd2, 32'h0000_A510, 8'h00, 8'd1, 1, 0);
        ack_delay = 0;
        exp_bus_q.push_back({1'b1, 8'h11, 8'h5A});
        run("write_fast", 8'h01, 8'd2, 32'h0000_5A11, 8'h00, 8'd1, 1, 5);

        // READ then immediate second READ
        exp_bus_q.push_back({1'b0, 8'h20, 8'h00});
        rd_q.push_back(8'h3C);
        run("read1", 8'h02, 8'd1, 32'h0000_0020, 8'h3C, 8'd1, 1, 5);
        exp_bus_q.push_back({1'b0, 8'h21, 8'h00});
        rd_q.push_back(8'hC3);
        run("read2", 8'h02, 8'd1, 32'h0000_0021, 8'hC3, 8'd1, 1, 5);

        // POLL: bit 7 appears on the third read
        ack_delay = 1;
        repeat (3) exp_bus_q.push_back({1'b0, 8'h04, 8'h00});
        rd_q.push_back(8'h00); rd_q.push_back(8'h7F); rd_q.push_back(8'h80);
        run("poll_hit", 8'h03, 8'd3, 32'h0080_8004, 8'h00, 8'd1, 3, 0);

        // POLL never matching: POLL_MAX=5 reads then 0xFF
        ack_delay = 0;
        repeat (5) exp_bus_q.push_back({1'b0, 8'h04, 8'h00});
        run("poll_to", 8'h03, 8'd3, 32'h0080_8004, 8'hFF, 8'd1, 5, 0);

        // Size mismatch / unknown opcode: 0xFE, no bus access
        run("bad_sz",   8'h01, 8'd3, 32'h0012_3456, 8'hFE, 8'd1, 0, 0);
        run("bad_op",   8'h7E, 8'd0, 32'h0,         8'hFE, 8'd1, 0, 0);
        run("bad_nop",  8'h00, 8'd1, 32'h0,         8'hFE, 8'd1, 0, 0);

`ifdef TBLINK_RPC_CMD_EXEC_BUSTO_EN
        // Watchdog: req high for 16 cycles then 0xFD
        never_ack = 1'b1;
        req_hi = 0;
        issue(8'h02, 8'd1, 32'h0000_0030, 8'hFD, 8'd1, 1'b1);
        cyc = 0;
        while (cmd_in_get_i !== cmd_in_put_i && cyc < 400) begin
            @(negedge uclock);
            cyc++;
            if (bus_req) req_hi++;
        end
        check("wd_done", {31'd0, cmd_in_get_i}, {31'd0, cmd_in_put_i});
        check("wd_req_cycles", req_hi, 16);
        check("wd_req_low", {31'd0, bus_req}, 0);
`endif

        // Reset while in BUS with no ack: request drops immediately, no response
        never_ack = 1'b1;
        issue(8'h02, 8'd1, 32'h0000_0040, 8'h00, 8'd0, 1'b0);
`ifdef TBLINK_RPC_CMD_EXEC_BUSTO_EN
        repeat (6) @(negedge uclock);
`else
        repeat (40) @(negedge uclock);
`endif
        check("bus_hold_req",  {31'd0, bus_req}, 1);
        check("bus_hold_busy", {31'd0, busy}, 1);
        check("bus_hold_addr", bus_addr, 8'h40);
        reset = 1'b1;
        #1;
        check("abort_req",  {31'd0, bus_req}, 0);
        check("abort_get",  {31'd0, cmd_in_get_i}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        cmd_in_put_i = 1'b0;
        never_ack    = 1'b0;
        @(negedge uclock);
        reset = 1'b0;
        @(negedge uclock);

        // Recovery after abort
        exp_bus_q.push_back({1'b0, 8'h22, 8'h00});
        rd_q.push_back(8'h99);
        run("read_after_rst", 8'h02, 8'd1, 32'h0000_0022, 8'h99, 8'd1, 1, 5);

        repeat (4) @(negedge uclock);
        check("rsp_q_empty", exp_rsp_q.size(), 0);
        check("bus_q_empty", exp_bus_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "global timeout");
    end

endmodule
